// File: rtl/mcs_io_pkg.sv
// Shared types and constants for the MCS I/O bus initiator.
package mcs_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [3:0]  RD_BE_ALL       = 4'hF;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/mcs_io_master.sv
// MCS I/O bus initiator: one bus transaction per request, bounded wait on io_ready.
// Optional macro MCS_IO_ADDR_CHECK_EN rejects addresses outside the BRG_BASE[31:24] window.
module mcs_io_master
    import mcs_io_pkg::*;
#(
    parameter logic [31:0] BRG_BASE    = 32'hC000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_address,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nx;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;
    rsp_t             rsp_q;
    logic             addr_ok;
    logic             timed_out;

`ifdef MCS_IO_ADDR_CHECK_EN
    assign addr_ok = (cmd_addr[31:24] == BRG_BASE[31:24]);
`else
    logic unused_base;
    assign unused_base = ^BRG_BASE;
    assign addr_ok     = 1'b1;
`endif

    // cnt holds the number of bus cycles already spent, STROBE being cycle 0
    assign timed_out = (cnt == CNT_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (cmd_valid) state_nx = addr_ok ? STROBE : RESP;
            STROBE, WAIT: if (io_ready || timed_out) state_nx = RESP;
                          else                       state_nx = WAIT;
            RESP:         if (rsp_ready) state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wr_q           <= 1'b0;
            cnt            <= '0;
            rsp_q          <= '0;
            io_address     <= '0;
            io_write_data  <= '0;
            io_byte_enable <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_valid) begin
                        if (addr_ok) begin
                            wr_q           <= cmd_wr;
                            io_address     <= cmd_addr & WORD_ALIGN_MASK;
                            io_byte_enable <= cmd_wr ? cmd_be : RD_BE_ALL;
                            if (cmd_wr) io_write_data <= cmd_wdata;
                            rsp_q          <= '0;
                        end else begin
                            rsp_q <= '{rdata: 32'h0, err: 1'b1};
                        end
                    end
                end
                STROBE, WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (io_ready)
                        rsp_q <= '{rdata: (wr_q ? 32'h0 : io_read_data), err: 1'b0};
                    else if (timed_out)
                        rsp_q <= '{rdata: 32'h0, err: 1'b1};
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them at once
    assign io_addr_strobe  = (state == STROBE);
    assign io_read_strobe  = (state == STROBE) && !wr_q;
    assign io_write_strobe = (state == STROBE) &&  wr_q;
    assign cmd_ready       = (state == IDLE);
    assign rsp_valid       = (state == RESP);
    assign rsp_rdata       = rsp_q.rdata;
    assign rsp_err         = rsp_q.err;

endmodule

// File: tb/tb_mcs_io_master.sv
// Randomized self-checking bench for mcs_io_master against a transaction-level model.
module tb_mcs_io_master;

    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic        io_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    mcs_io_master #(.BRG_BASE(BASE), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
`ifdef MCS_IO_ADDR_CHECK_EN
        return a[31:24] == BASE[31:24];
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_strobes", {io_addr_strobe, io_read_strobe, io_write_strobe}, 0);
        chk("rst_io_address", io_address, 0);
        chk("rst_io_wdata", io_write_data, 0);
        chk("rst_io_be", io_byte_enable, 0);
    endtask

    // One command: io_ready arrives `delay` cycles after the strobe cycle,
    // the response is held for `hold` cycles before rsp_ready.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int delay, input logic [31:0] rdata,
                           input int hold);
        logic        ok, exp_err;
        logic [31:0] exp_rd;
        int          last_k;
        ok = addr_ok(addr);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        io_ready = 1'($urandom);
        io_read_data = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        cmd_addr  = $urandom;
        if (ok) begin
            exp_err = (delay >= TO);
            exp_rd  = (wr || exp_err) ? 32'h0 : rdata;
            last_k  = exp_err ? TO - 1 : delay;
            if (wr) last_wdata = wdata;
            for (int k = 0; k <= last_k; k++) begin
                if (k > 0) @(negedge clk);
                chk("addr_strobe", io_addr_strobe, k == 0);
                chk("rd_strobe", io_read_strobe, (k == 0) && !wr);
                chk("wr_strobe", io_write_strobe, (k == 0) && wr);
                chk("io_address", io_address, {addr[31:2], 2'b00});
                chk("io_be", io_byte_enable, wr ? be : 4'hF);
                chk("io_wdata", io_write_data, last_wdata);
                chk("rsp_valid_busy", rsp_valid, 0);
                chk("cmd_ready_busy", cmd_ready, 0);
                io_ready     = (k == delay);
                io_read_data = (k == delay) ? rdata : $urandom;
            end
            @(negedge clk);
        end else begin
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", rsp_err, exp_err);
            chk("cmd_ready_resp", cmd_ready, 0);
            chk("strobe_resp", {io_addr_strobe, io_read_strobe, io_write_strobe}, 0);
            rsp_ready    = (h == hold);
            io_ready     = 1'($urandom);
            io_read_data = $urandom;
            if (hold > 0) begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'($urandom);
                cmd_addr  = BASE | 32'h0000_0FF0;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b0; io_ready = 1'b0;
        chk("rsp_valid_done", rsp_valid, 0);
        chk("cmd_ready_done", cmd_ready, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        rsp_ready = 1'b0; io_read_data = '0; io_ready = 1'b0;
        last_wdata = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_txn(1'b1, 32'hC000_0010, 32'h1234_5678, 4'b0011, 0, 32'h0, 0);
        run_txn(1'b0, 32'hC080_0004, 32'h0, 4'h0, 3, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 32'hC000_0020, 32'h0, 4'h0, 100, 32'hDEAD_BEEF, 2);
        run_txn(1'b0, 32'hC000_0024, 32'h0, 4'h0, 1, 32'h0BAD_CAFE, 5);
        run_txn(1'b0, 32'hC000_0028, 32'h0, 4'h0, TO - 1, 32'h1111_2222, 0);
        run_txn(1'b0, 32'h4000_0000, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1);

        // Abort a transaction with reset while its strobe is on the bus
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'hC000_0100;
        cmd_wdata = 32'hA5A5_5A5A; cmd_be = 4'hC;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_strobe_before", io_addr_strobe, 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        last_wdata = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
            chk("abort_idle", cmd_ready, 1);
        end
        run_txn(1'b0, 32'hC000_0104, 32'h0, 4'h0, 2, 32'h7777_8888, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : {8'hC0, 24'($urandom)};
            run_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 20),
                    $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
